mips_multicycle_controller: RTL and testbench

Sequencing controller for the multicycle MIPS core. It holds the instruction-phase state machine and decodes opcode/funct into per-cycle datapath strobes, mux selects and ALU control. It stalls on a single shared instruction/data memory port through a request/ready handshake. It sits beside the shared PC/IR/register-file/ALU datapath and is the only block that writes PC, IR and the register file.

---
 rtl/mips_multicycle_controller_if.sv | 22 ++
 rtl/mips_multicycle_controller.sv | 188 ++++++++++++++++++
 tb/tb_mips_multicycle_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_controller_if.sv
// Shared instruction/data memory port between the controller and the memory.
// Requests stay asserted and stable until the memory answers with mem_ready.
interface mips_multicycle_controller_if;
    logic mem_req;
    logic mem_write;
    logic i_or_d;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_write,
        output i_or_d,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_write,
        input  i_or_d,
        output mem_ready
    );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS sequencing controller: instruction-phase FSM plus decode of
// opcode/funct into per-cycle datapath strobes, mux selects and ALU control.
module mips_multicycle_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    input  logic        zero_i,
    mips_multicycle_controller_if.master mem,
    output logic        ir_write_o,
    output logic        pc_en_o,
    output logic [1:0]  pc_src_o,
    output logic        alu_src_a_o,
    output logic [1:0]  alu_src_b_o,
    output logic [2:0]  alu_ctrl_o,
    output logic        reg_write_o,
    output logic        reg_dst_o,
    output logic        mem_to_reg_o,
    output logic        retire_o,
    output logic        illegal_o
);
    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
        StRtExec, StRtWb, StBranch, StAddiExec, StAddiWb, StJump
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluSlt = 3'b111;

    state_e     state_q, state_d, state_nx;
    logic       is_sw_q;
    logic       op_ok, funct_ok;
    logic [2:0] rt_alu;

    logic       mem_req_q, mem_write_q, i_or_d_q, alu_src_a_q;
    logic       reg_write_q, reg_dst_q, mem_to_reg_q, retire_q;
    logic [1:0] pc_src_q, alu_src_b_q;
    logic [2:0] alu_base_q;

    always_comb begin
        op_ok = 1'b1;
        unique case (opcode_i)
            OpRtype, OpLw, OpSw, OpBeq, OpAddi, OpJ: op_ok = 1'b1;
            default:                                 op_ok = 1'b0;
        endcase
    end

    always_comb begin
        funct_ok = 1'b1;
        rt_alu   = AluAdd;
        unique case (funct_i)
            6'b100000: rt_alu = AluAdd;
            6'b100010: rt_alu = AluSub;
            6'b100100: rt_alu = AluAnd;
            6'b100101: rt_alu = AluOr;
            6'b101010: rt_alu = AluSlt;
            default:   funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  if (mem.mem_ready) state_d = StDecode;
            StDecode: begin
                unique case (opcode_i)
                    OpRtype:   state_d = StRtExec;
                    OpLw, OpSw: state_d = StMemAdr;
                    OpBeq:     state_d = StBranch;
                    OpAddi:    state_d = StAddiExec;
                    OpJ:       state_d = StJump;
                    default:   state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = is_sw_q ? StMemWr : StMemRd;
            StMemRd:    if (mem.mem_ready) state_d = StMemWb;
            StMemWr:    if (mem.mem_ready) state_d = StFetch;
            StRtExec:   state_d = funct_ok ? StRtWb : StFetch;
            StAddiExec: state_d = StAddiWb;
            default:    state_d = StFetch;
        endcase
    end

    // Outputs are registered from the upcoming state so they line up with state_q.
    assign state_nx = rst ? StFetch : state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) is_sw_q <= (opcode_i == OpSw);
        end

        mem_req_q    <= 1'b0;
        mem_write_q  <= 1'b0;
        i_or_d_q     <= 1'b0;
        pc_src_q     <= 2'b00;
        alu_src_a_q  <= 1'b0;
        alu_src_b_q  <= 2'b00;
        alu_base_q   <= 3'b000;
        reg_write_q  <= 1'b0;
        reg_dst_q    <= 1'b0;
        mem_to_reg_q <= 1'b0;
        retire_q     <= 1'b0;
        unique case (state_nx)
            StFetch: begin
                mem_req_q   <= 1'b1;
                alu_src_b_q <= 2'b01;
                alu_base_q  <= AluAdd;
            end
            StDecode: begin
                alu_src_b_q <= 2'b11;
                alu_base_q  <= AluAdd;
            end
            StMemAdr, StAddiExec: begin
                alu_src_a_q <= 1'b1;
                alu_src_b_q <= 2'b10;
                alu_base_q  <= AluAdd;
            end
            StMemRd: begin
                mem_req_q <= 1'b1;
                i_or_d_q  <= 1'b1;
            end
            StMemWb: begin
                reg_write_q  <= 1'b1;
                mem_to_reg_q <= 1'b1;
                retire_q     <= 1'b1;
            end
            StMemWr: begin
                mem_req_q   <= 1'b1;
                mem_write_q <= 1'b1;
                i_or_d_q    <= 1'b1;
            end
            StRtExec: alu_src_a_q <= 1'b1;
            StRtWb: begin
                reg_write_q <= 1'b1;
                reg_dst_q   <= 1'b1;
                retire_q    <= 1'b1;
            end
            StBranch: begin
                alu_src_a_q <= 1'b1;
                alu_base_q  <= AluSub;
                pc_src_q    <= 2'b01;
                retire_q    <= 1'b1;
            end
            StAddiWb: begin
                reg_write_q <= 1'b1;
                retire_q    <= 1'b1;
            end
            StJump: begin
                pc_src_q <= 2'b10;
                retire_q <= 1'b1;
            end
            default: ;
        endcase
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_write = mem_write_q;
    assign mem.i_or_d    = i_or_d_q;
    assign pc_src_o      = pc_src_q;
    assign alu_src_a_o   = alu_src_a_q;
    assign alu_src_b_o   = alu_src_b_q;
    assign alu_ctrl_o    = (state_q == StRtExec) ? rt_alu : alu_base_q;
    assign reg_write_o   = reg_write_q;
    assign reg_dst_o     = reg_dst_q;
    assign mem_to_reg_o  = mem_to_reg_q;

    // Strobes qualified by same-cycle handshake or flags.
    assign ir_write_o = (state_q == StFetch) && mem.mem_ready;
    assign pc_en_o    = ((state_q == StFetch) && mem.mem_ready) || (state_q == StJump) ||
                        ((state_q == StBranch) && zero_i);
    assign retire_o   = retire_q || ((state_q == StMemWr) && mem.mem_ready);
    assign illegal_o  = ((state_q == StDecode) && !op_ok) ||
                        ((state_q == StRtExec) && !funct_ok);
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed-vector bench: every cycle compares the full packed output word
// against a hand-written expected word for the state the FSM should be in.
module tb_mips_multicycle_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       ir_write, pc_en, alu_src_a, reg_write, reg_dst, mem_to_reg, retire, illegal;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_ctrl;
    logic [17:0] outv;
    int n_cmp = 0;
    int n_err = 0;

    mips_multicycle_controller_if mif ();

    mips_multicycle_controller dut (
        .clk          (clk),
        .rst          (rst),
        .opcode_i     (opcode),
        .funct_i      (funct),
        .zero_i       (zero),
        .mem          (mif.master),
        .ir_write_o   (ir_write),
        .pc_en_o      (pc_en),
        .pc_src_o     (pc_src),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .alu_ctrl_o   (alu_ctrl),
        .reg_write_o  (reg_write),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .retire_o     (retire),
        .illegal_o    (illegal)
    );

    always #5 clk = ~clk;

    // {req, wr, iord, irw, pcen, pc_src, src_a, src_b, alu, rw, rdst, m2r, ret, ill}
    assign outv = {mif.mem_req, mif.mem_write, mif.i_or_d, ir_write, pc_en, pc_src,
                   alu_src_a, alu_src_b, alu_ctrl, reg_write, reg_dst, mem_to_reg,
                   retire, illegal};

    localparam logic [17:0] V_FETCH_W = {5'b10000, 2'b00, 1'b0, 2'b01, 3'b010, 5'b00000};
    localparam logic [17:0] V_FETCH_R = {5'b10011, 2'b00, 1'b0, 2'b01, 3'b010, 5'b00000};
    localparam logic [17:0] V_DECODE  = {5'b00000, 2'b00, 1'b0, 2'b11, 3'b010, 5'b00000};
    localparam logic [17:0] V_DEC_ILL = {5'b00000, 2'b00, 1'b0, 2'b11, 3'b010, 5'b00001};
    localparam logic [17:0] V_MEMADR  = {5'b00000, 2'b00, 1'b1, 2'b10, 3'b010, 5'b00000};
    localparam logic [17:0] V_MEMRD   = {5'b10100, 2'b00, 1'b0, 2'b00, 3'b000, 5'b00000};
    localparam logic [17:0] V_MEMWB   = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 5'b10110};
    localparam logic [17:0] V_MEMWR_W = {5'b11100, 2'b00, 1'b0, 2'b00, 3'b000, 5'b00000};
    localparam logic [17:0] V_MEMWR_R = {5'b11100, 2'b00, 1'b0, 2'b00, 3'b000, 5'b00010};
    localparam logic [17:0] V_RT_SLT  = {5'b00000, 2'b00, 1'b1, 2'b00, 3'b111, 5'b00000};
    localparam logic [17:0] V_RT_SUB  = {5'b00000, 2'b00, 1'b1, 2'b00, 3'b110, 5'b00000};
    localparam logic [17:0] V_RT_ILL  = {5'b00000, 2'b00, 1'b1, 2'b00, 3'b010, 5'b00001};
    localparam logic [17:0] V_RTWB    = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 5'b11010};
    localparam logic [17:0] V_BR_T    = {5'b00001, 2'b01, 1'b1, 2'b00, 3'b110, 5'b00010};
    localparam logic [17:0] V_BR_NT   = {5'b00000, 2'b01, 1'b1, 2'b00, 3'b110, 5'b00010};
    localparam logic [17:0] V_ADDIEX  = {5'b00000, 2'b00, 1'b1, 2'b10, 3'b010, 5'b00000};
    localparam logic [17:0] V_ADDIWB  = {5'b00000, 2'b00, 1'b0, 2'b00, 3'b000, 5'b10010};
    localparam logic [17:0] V_JUMP    = {5'b00001, 2'b10, 1'b0, 2'b00, 3'b000, 5'b00010};

    task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Inputs are set before the call; outputs are sampled on the falling edge.
    task automatic cyc(input string tag, input logic [17:0] exp);
        @(negedge clk);
        check_eq(tag, outv, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mif.mem_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        cyc("reset_fetch", V_FETCH_W);
        rst = 1'b0;

        // Reset in the middle of a stalled lw read.
        opcode = 6'b100011; mif.mem_ready = 1'b1;
        cyc("rst_lw_fetch", V_FETCH_R);
        cyc("rst_lw_decode", V_DECODE);
        cyc("rst_lw_memadr", V_MEMADR);
        mif.mem_ready = 1'b0;
        cyc("rst_lw_memrd", V_MEMRD);
        rst = 1'b1;
        cyc("rst_lw_memrd_rst", V_MEMRD);
        rst = 1'b0;
        cyc("rst_after_fetch", V_FETCH_W);

        // lw, zero-wait; opcode change after DECODE must not redirect to MEMWR.
        mif.mem_ready = 1'b1;
        cyc("lw_fetch", V_FETCH_R);
        cyc("lw_decode", V_DECODE);
        opcode = 6'b101011;
        cyc("lw_memadr", V_MEMADR);
        cyc("lw_memrd", V_MEMRD);
        cyc("lw_memwb", V_MEMWB);

        // sw with three wait cycles.
        opcode = 6'b101011;
        cyc("sw_fetch", V_FETCH_R);
        cyc("sw_decode", V_DECODE);
        cyc("sw_memadr", V_MEMADR);
        mif.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("sw_memwr_wait", V_MEMWR_W);
        mif.mem_ready = 1'b1;
        cyc("sw_memwr_done", V_MEMWR_R);

        // beq taken then not taken.
        opcode = 6'b000100; zero = 1'b1;
        cyc("beq_t_fetch", V_FETCH_R);
        cyc("beq_t_decode", V_DECODE);
        cyc("beq_t_branch", V_BR_T);
        zero = 1'b0;
        cyc("beq_nt_fetch", V_FETCH_R);
        cyc("beq_nt_decode", V_DECODE);
        cyc("beq_nt_branch", V_BR_NT);

        // R-type slt, sub, then an illegal funct.
        opcode = 6'b000000; funct = 6'b101010;
        cyc("slt_fetch", V_FETCH_R);
        cyc("slt_decode", V_DECODE);
        cyc("slt_rtexec", V_RT_SLT);
        cyc("slt_rtwb", V_RTWB);
        funct = 6'b100010;
        cyc("sub_fetch", V_FETCH_R);
        cyc("sub_decode", V_DECODE);
        cyc("sub_rtexec", V_RT_SUB);
        cyc("sub_rtwb", V_RTWB);
        funct = 6'b000111;
        cyc("badf_fetch", V_FETCH_R);
        cyc("badf_decode", V_DECODE);
        cyc("badf_rtexec", V_RT_ILL);
        mif.mem_ready = 1'b0;
        cyc("badf_next_fetch", V_FETCH_W);
        mif.mem_ready = 1'b1;

        // addi and j.
        opcode = 6'b001000;
        cyc("addi_fetch", V_FETCH_R);
        cyc("addi_decode", V_DECODE);
        cyc("addi_exec", V_ADDIEX);
        cyc("addi_wb", V_ADDIWB);
        opcode = 6'b000010;
        cyc("j_fetch", V_FETCH_R);
        cyc("j_decode", V_DECODE);
        cyc("j_jump", V_JUMP);

        // Illegal opcode.
        opcode = 6'b111111;
        cyc("badop_fetch", V_FETCH_R);
        cyc("badop_decode", V_DEC_ILL);
        mif.mem_ready = 1'b0;
        cyc("badop_next_fetch", V_FETCH_W);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
